// File: rtl/avalon_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_st_if
// Purpose  : Avalon-ST streaming bundle (data, valid, rdy, sop, eop, empty)
//            with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
) ();
  localparam int EMPTY_WIDTH = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_WIDTH-1:0]           empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface
`default_nettype wire

// File: rtl/avalon_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : avalon_packetizer
// Purpose  : Frames an unframed word stream into Avalon-ST packets using a
//            per-packet byte-length command (sop/eop/empty generation).
//            DATA_WIDTH_IN_BYTES must be a power of two, at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_packetizer #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_st_if.slave           raw_msg,
  input  logic [LEN_WIDTH-1:0] pkt_len_bytes,
  input  logic                 pkt_len_valid,
  output logic                 pkt_len_rdy,
  avalon_st_if.master          framed_msg,
  output logic                 zero_len_indi,
  output logic [15:0]          pkt_done_cnt
);
  localparam int EW = $clog2(DATA_WIDTH_IN_BYTES);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] words_total;
  logic [LEN_WIDTH-1:0] word_idx;
  logic [EW-1:0]        last_empty;

  logic [EW-1:0]        len_rem;
  logic [EW-1:0]        len_empty;
  logic [LEN_WIDTH-1:0] len_words;
  logic                 cmd_accept;
  logic                 cmd_zero;
  logic                 is_last;
  logic                 beat_fire;

  // Framing fields on the raw side carry no meaning and are discarded.
  logic unused_raw_fields;
  assign unused_raw_fields = ^{raw_msg.sop, raw_msg.eop, raw_msg.empty};

  // Shift-based ceil division: the quotient of a LEN_WIDTH value by
  // 2^EW leaves EW bits of headroom, so adding the round-up bit never wraps.
  assign len_rem    = pkt_len_bytes[EW-1:0];
  assign len_words  = (pkt_len_bytes >> EW) + {{(LEN_WIDTH-1){1'b0}}, |len_rem};
  assign len_empty  = ~len_rem + 1'b1;
  assign cmd_accept = pkt_len_valid && pkt_len_rdy;
  assign cmd_zero   = (pkt_len_bytes == '0);
  assign is_last    = (word_idx == words_total - 1'b1);
  assign beat_fire  = (state == ACTIVE) && raw_msg.valid && framed_msg.rdy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and combinational passthrough/framing outputs.
  always_comb begin
    state_nxt        = state;
    pkt_len_rdy      = 1'b0;
    raw_msg.rdy      = 1'b0;
    framed_msg.data  = raw_msg.data;
    framed_msg.valid = 1'b0;
    framed_msg.sop   = 1'b0;
    framed_msg.eop   = 1'b0;
    framed_msg.empty = '0;
    case (state)
      IDLE: begin
        pkt_len_rdy = 1'b1;
        if (pkt_len_valid && !cmd_zero) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        framed_msg.valid = raw_msg.valid;
        raw_msg.rdy      = framed_msg.rdy;
        framed_msg.sop   = raw_msg.valid && (word_idx == '0);
        framed_msg.eop   = raw_msg.valid && is_last;
        if (raw_msg.valid && is_last) begin
          framed_msg.empty = last_empty;
        end
        if (beat_fire && is_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Packet bookkeeping: length latch, beat index, drop pulse, done counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_total   <= '0;
      word_idx      <= '0;
      last_empty    <= '0;
      zero_len_indi <= 1'b0;
      pkt_done_cnt  <= '0;
    end else begin
      zero_len_indi <= cmd_accept && cmd_zero;
      if (cmd_accept && !cmd_zero) begin
        words_total <= len_words;
        last_empty  <= len_empty;
        word_idx    <= '0;
      end else if (beat_fire) begin
        if (is_last) begin
          word_idx     <= '0;
          pkt_done_cnt <= pkt_done_cnt + 16'd1;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_avalon_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_packetizer
// Purpose  : Scoreboard bench for avalon_packetizer (DW=16, LEN_WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_packetizer;
  localparam int DW = 16;
  localparam int LW = 16;

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic [3:0]   empty;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] pkt_len_bytes;
  logic          pkt_len_valid;
  logic          pkt_len_rdy;
  logic          zero_len_indi;
  logic [15:0]   pkt_done_cnt;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) raw_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) framed_if ();

  avalon_packetizer #(.DATA_WIDTH_IN_BYTES(DW), .LEN_WIDTH(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_msg       (raw_if),
    .pkt_len_bytes (pkt_len_bytes),
    .pkt_len_valid (pkt_len_valid),
    .pkt_len_rdy   (pkt_len_rdy),
    .framed_msg    (framed_if),
    .zero_len_indi (zero_len_indi),
    .pkt_done_cnt  (pkt_done_cnt)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt     = 16'd0;

  function automatic logic [127:0] word_of(input logic [15:0] tag, input int idx);
    logic [15:0] i16;
    i16 = idx[15:0];
    return {4{tag, i16}};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats for one packet, built from hand-computed word count / empty.
  task automatic push_pkt(input logic [15:0] tag, input int nwords, input logic [3:0] lempty);
    beat_t b;
    for (int i = 0; i < nwords; i++) begin
      b.data  = word_of(tag, i);
      b.sop   = (i == 0);
      b.eop   = (i == nwords - 1);
      b.empty = (i == nwords - 1) ? lempty : 4'd0;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_cmd(input logic [15:0] len);
    logic acc;
    acc           = 1'b0;
    pkt_len_bytes = len;
    pkt_len_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = pkt_len_rdy;
      tick();
    end
    pkt_len_valid = 1'b0;
    if (!acc) check("cmd_accept_timeout", 160'd0, 160'd1);
  endtask

  // Streams nsend words of packet tag; on beat stall_beat the sink stalls 3 cycles.
  task automatic send_words(input logic [15:0] tag, input int nsend, input int stall_beat, input int nwords);
    int   i;
    int   stalls;
    int   budget;
    logic ok;
    i = 0; stalls = 0; budget = 0;
    while (i < nsend && budget < 20000) begin
      budget++;
      raw_if.valid = 1'b1;
      raw_if.data  = word_of(tag, i);
      if (i == stall_beat && stalls < 3) begin
        framed_if.rdy = 1'b0;
        #1;
        check("stall_raw_rdy", {159'd0, raw_if.rdy}, 160'd0);
        check("stall_data", {32'd0, framed_if.data}, {32'd0, word_of(tag, i)});
        check("stall_sop_eop", {158'd0, framed_if.sop, framed_if.eop},
              {158'd0, 1'b0, (i == nwords - 1)});
        stalls++;
        tick();
      end else begin
        framed_if.rdy = 1'b1;
        #1;
        ok = raw_if.rdy;
        tick();
        if (ok) i++;
      end
    end
    raw_if.valid  = 1'b0;
    framed_if.rdy = 1'b1;
    if (i < nsend) check("send_words_timeout", 160'd0, 160'd1);
  endtask

  task automatic run_pkt(input logic [15:0] tag, input logic [15:0] len, input int nwords,
                         input logic [3:0] lempty, input int stall_beat);
    push_pkt(tag, nwords, lempty);
    send_cmd(len);
    send_words(tag, nwords, stall_beat, nwords);
    exp_cnt = exp_cnt + 16'd1;
    check("pkt_done_cnt", {144'd0, pkt_done_cnt}, {144'd0, exp_cnt});
  endtask

  task automatic check_reset_outputs();
    check("rst_len_rdy", {159'd0, pkt_len_rdy}, 160'd1);
    check("rst_valid_sop_eop", {157'd0, framed_if.valid, framed_if.sop, framed_if.eop}, 160'd0);
    check("rst_empty", {156'd0, framed_if.empty}, 160'd0);
    check("rst_raw_rdy", {159'd0, raw_if.rdy}, 160'd0);
    check("rst_zero_len", {159'd0, zero_len_indi}, 160'd0);
    check("rst_done_cnt", {144'd0, pkt_done_cnt}, 160'd0);
  endtask

  // Monitor: every transferred output beat is popped and compared.
  always @(negedge clk) begin
    if (!rst && framed_if.valid && framed_if.rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {26'd0, framed_if.data, framed_if.sop, framed_if.eop, framed_if.empty}, 160'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", {26'd0, framed_if.data, framed_if.sop, framed_if.eop, framed_if.empty},
              {26'd0, e});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    pkt_len_bytes = '0;
    pkt_len_valid = 1'b0;
    raw_if.valid  = 1'b0;
    raw_if.data   = '0;
    raw_if.sop    = 1'b0;
    raw_if.eop    = 1'b0;
    raw_if.empty  = '0;
    framed_if.rdy = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // 40 bytes: 3 beats, empty 8 on the last.
    run_pkt(16'h0001, 16'd40, 3, 4'd8, -1);

    // 32 then 1 byte back-to-back, with the idle cycle in between observed.
    run_pkt(16'h0002, 16'd32, 2, 4'd0, -1);
    raw_if.valid = 1'b1;
    raw_if.data  = word_of(16'h0003, 0);
    #1;
    check("idle_gap_valid", {158'd0, framed_if.valid, pkt_len_rdy}, {158'd0, 1'b0, 1'b1});
    run_pkt(16'h0003, 16'd1, 1, 4'd15, -1);

    // Zero-length command is dropped with a one-cycle pulse; raw words untouched.
    raw_if.valid = 1'b1;
    raw_if.data  = word_of(16'h00EE, 0);
    send_cmd(16'd0);
    check("zero_pulse", {159'd0, zero_len_indi}, 160'd1);
    check("zero_idle", {157'd0, pkt_len_rdy, framed_if.valid, raw_if.rdy}, {157'd0, 3'b100});
    tick();
    check("zero_pulse_end", {159'd0, zero_len_indi}, 160'd0);
    check("zero_still_idle", {158'd0, pkt_len_rdy, framed_if.valid}, {158'd0, 2'b10});
    raw_if.valid = 1'b0;

    // 48 bytes with a 3-cycle sink stall on beat 1.
    run_pkt(16'h0004, 16'd48, 3, 4'd0, 1);
    // 17 bytes: 2 beats, empty 15.
    run_pkt(16'h0005, 16'd17, 2, 4'd15, -1);
    // Maximum length: 4096 beats, empty 1.
    run_pkt(16'h0006, 16'hFFFF, 4096, 4'd1, -1);

    // 64 bytes abandoned by reset after two beats.
    push_pkt(16'h0007, 4, 4'd0);
    send_cmd(16'd64);
    send_words(16'h0007, 2, -1, 4);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
    tick();
    run_pkt(16'h0008, 16'd16, 1, 4'd0, -1);

    // Counter wrap from 0xFFFF.
    force dut.pkt_done_cnt = 16'hFFFF;
    tick();
    release dut.pkt_done_cnt;
    tick();
    check("cnt_preload", {144'd0, pkt_done_cnt}, {144'd0, 16'hFFFF});
    exp_cnt = 16'hFFFF;
    run_pkt(16'h0009, 16'd1, 1, 4'd15, -1);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("queue_drained", 160'(exp_q.size()), 160'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
